mips_mdu: RTL and testbench

Parametrised multiply/divide unit for the pipelined MIPS core, sitting in the EX stage beside the ALU. It owns the HI/LO register pair. It executes MULT/MULTU/DIV/DIVU with configurable fixed latencies and MTHI/MTLO in one cycle. It raises `busy` so the hazard unit can stall any later MDU instruction, including MFHI/MFLO.

---
 rtl/mips_mdu_pkg.sv | 52 +++++
 rtl/mips_mdu_calc.sv | 65 ++++++
 rtl/mips_mdu.sv | 139 +++++++++++++
 tb/tb_mips_mdu.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mips_mdu_pkg.sv
// mips_mdu_pkg: shared op codes, request/commit types, latency defaults and op classifiers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a. MIPS_MDU_MADD_EN enables the multiply-accumulate op codes.
package mips_mdu_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } mdu_op_e;

  // MADDU/MSUBU travel as OP_MADD/OP_MSUB with uns set.
  typedef struct packed {
    mdu_op_e op;
    logic    uns;
  } mdu_req_t;

  // What the pending result does to {hi,lo} when the counter expires.
  typedef enum logic [1:0] {
    CMT_SET  = 2'd0,
    CMT_NONE = 2'd1,
    CMT_ADD  = 2'd2,
    CMT_SUB  = 2'd3
  } commit_e;

  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;

  // Ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_long_op(input logic [2:0] op);
    logic r;
    r = 1'b0;
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3: r = 1'b1;
`ifdef MIPS_MDU_MADD_EN
      3'd6, 3'd7:             r = 1'b1;
`endif
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == 3'd2) || (op == 3'd3);
  endfunction

endpackage

// File: rtl/mips_mdu_calc.sv
// mips_mdu_calc: combinational product / quotient / remainder for the MDU.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the parent samples the result on the issue edge.
module mips_mdu_calc
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_req_t           req_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               div_zero_o
);

  logic               sgn;
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  // Signedness, then a 2W-bit product of the (sign- or zero-) extended operands:
  // the low 2W bits of that product equal the signed/unsigned product exactly.
  always_comb begin
    sgn = 1'b0;
    case (req_i.op)
      OP_MULT, OP_DIV:   sgn = 1'b1;
      OP_MADD, OP_MSUB:  sgn = ~req_i.uns;
      default:           sgn = 1'b0;
    endcase
    a_ext = sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
    b_ext = sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
    prod  = a_ext * b_ext;
  end

  // Sign-magnitude division: truncating quotient, remainder takes the dividend's sign.
  // Most-negative / -1 falls out as quotient = most-negative, remainder = 0.
  always_comb begin
    a_neg      = sgn & a_i[WIDTH-1];
    b_neg      = sgn & b_i[WIDTH-1];
    a_mag      = a_neg ? (-a_i) : a_i;
    b_mag      = b_neg ? (-b_i) : b_i;
    div_zero_o = (b_i == '0);
    q_mag      = div_zero_o ? '0 : (a_mag / b_mag);
    r_mag      = div_zero_o ? '0 : (a_mag % b_mag);
    quot       = (a_neg ^ b_neg) ? (-q_mag) : q_mag;
    rem        = a_neg ? (-r_mag) : r_mag;
    if (is_div_op(req_i.op)) begin
      hi_o = rem;
      lo_o = quot;
    end else begin
      hi_o = prod[2*WIDTH-1:WIDTH];
      lo_o = prod[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mips_mdu.sv
// mips_mdu: HI/LO owner; MULT/MULTU/DIV/DIVU with fixed latencies, MTHI/MTLO in one edge.
// Latency: MULT_LAT / DIV_LAT edges to HI/LO commit, 1 edge for MTHI/MTLO.
// Backpressure: busy + combinational stall_req; starts during busy are dropped, except a
// long op on the edge busy falls. MIPS_MDU_MADD_EN adds MADD/MADDU/MSUB/MSUBU.
module mips_mdu
  import mips_mdu_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mdu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MIPS_MDU_MADD_EN
  input  logic             madd_uns,
`endif
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             stall_req
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic               busy_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic [2*WIDTH-1:0] pend_q;
  commit_e            pend_kind_q;

  mdu_req_t           req;
  logic [WIDTH-1:0]   calc_hi;
  logic [WIDTH-1:0]   calc_lo;
  logic               calc_dz;
  logic               long_op;
  logic               commit;
  logic               issue_long;
  logic               issue_mt;
  commit_e            issue_kind;
  logic [CW-1:0]      issue_lat;

  // Decode the request; a long op may also issue on the edge the current one commits.
  always_comb begin
    req.op     = mdu_op_e'(mdu_op);
`ifdef MIPS_MDU_MADD_EN
    req.uns    = madd_uns;
`else
    req.uns    = 1'b0;
`endif
    long_op    = is_long_op(mdu_op);
    commit     = (state_q == S_BUSY) && (cnt_q == CW'(1));
    issue_long = start && long_op && ((state_q == S_IDLE) || commit);
    issue_mt   = start && (state_q == S_IDLE) &&
                 ((req.op == OP_MTHI) || (req.op == OP_MTLO));
    issue_lat  = is_div_op(mdu_op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
    issue_kind = CMT_SET;
    case (req.op)
      OP_DIV, OP_DIVU: issue_kind = calc_dz ? CMT_NONE : CMT_SET;
`ifdef MIPS_MDU_MADD_EN
      OP_MADD:         issue_kind = CMT_ADD;
      OP_MSUB:         issue_kind = CMT_SUB;
`endif
      default:         issue_kind = CMT_SET;
    endcase
  end

  mips_mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .req_i      (req),
    .a_i        (a),
    .b_i        (b),
    .hi_o       (calc_hi),
    .lo_o       (calc_lo),
    .div_zero_o (calc_dz)
  );

`ifdef MIPS_MDU_MADD_EN
  logic [2*WIDTH-1:0] acc_d;

  // Accumulate against the architectural {hi,lo} as it stands at commit time.
  always_comb begin
    acc_d = (pend_kind_q == CMT_SUB) ? ({hi_q, lo_q} - pend_q) : ({hi_q, lo_q} + pend_q);
  end
`endif

  // Counter FSM: issue loads the latency, the 1->0 step commits and drops busy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      pend_q      <= '0;
      pend_kind_q <= CMT_SET;
    end else begin
      if (commit) begin
        case (pend_kind_q)
          CMT_SET: {hi_q, lo_q} <= pend_q;
`ifdef MIPS_MDU_MADD_EN
          CMT_ADD, CMT_SUB: {hi_q, lo_q} <= acc_d;
`endif
          default: ;
        endcase
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else if (state_q == S_BUSY) begin
        cnt_q <= cnt_q - CW'(1);
      end
      // Issue after commit so a back-to-back op overrides the return to idle.
      if (issue_long) begin
        pend_q      <= {calc_hi, calc_lo};
        pend_kind_q <= issue_kind;
        cnt_q       <= issue_lat;
        state_q     <= S_BUSY;
        busy_q      <= 1'b1;
      end
      if (issue_mt) begin
        if (req.op == OP_MTHI) hi_q <= a;
        else                   lo_q <= a;
      end
    end
  end

  assign busy      = busy_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign stall_req = busy_q | (start & long_op);

endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: table-driven vectors plus hand sequences for the multi-cycle corners.
module tb_mips_mdu;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        stall_req;
`ifdef MIPS_MDU_MADD_EN
  logic        madd_uns = 1'b0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mips_mdu #(.WIDTH(32), .MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mdu_op    (mdu_op),
    .a         (a),
    .b         (b),
`ifdef MIPS_MDU_MADD_EN
    .madd_uns  (madd_uns),
`endif
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .stall_req (stall_req)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] va;
    logic [31:0] vb;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] va, vb, ehi, elo,
                              input int lat);
    vec_t v;
    v.op = op; v.va = va; v.vb = vb; v.ehi = ehi; v.elo = elo; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; the op is sampled at the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    start = 1'b1; mdu_op = op; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count consecutive negedge samples with busy high; bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int nb;

    vq.push_back(mk(3'd0, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, ML));
    vq.push_back(mk(3'd1, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, ML));
    vq.push_back(mk(3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DL));
    vq.push_back(mk(3'd3, 32'd7,        32'd0,        32'hFFFFFFFF, 32'hFFFFFFFD, DL));
    vq.push_back(mk(3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DL));
    vq.push_back(mk(3'd2, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DL));
    vq.push_back(mk(3'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, DL));
    vq.push_back(mk(3'd4, 32'h12345678, 32'd0,        32'h12345678, 32'h0FFFFFFF, 0));
    vq.push_back(mk(3'd5, 32'hCAFEBABE, 32'd0,        32'h12345678, 32'hCAFEBABE, 0));
    vq.push_back(mk(3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, ML));
    vq.push_back(mk(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, ML));
    vq.push_back(mk(3'd0, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, ML));
    vq.push_back(mk(3'd4, 32'd0,        32'd0,        32'h00000000, 32'h80000001, 0));
    vq.push_back(mk(3'd5, 32'd10,       32'd0,        32'h00000000, 32'h0000000A, 0));
`ifdef MIPS_MDU_MADD_EN
    vq.push_back(mk(3'd6, 32'd3,        32'd4,        32'h00000000, 32'h00000016, ML));
    vq.push_back(mk(3'd7, 32'd5,        32'd5,        32'hFFFFFFFF, 32'hFFFFFFFD, ML));
`else
    vq.push_back(mk(3'd6, 32'd3,        32'd4,        32'h00000000, 32'h0000000A, 0));
    vq.push_back(mk(3'd7, 32'd5,        32'd5,        32'h00000000, 32'h0000000A, 0));
`endif

    // Reset state.
    #12 reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall_req}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);

    // Table vectors: busy duration, then committed HI/LO.
    for (int i = 0; i < vq.size(); i++) begin
      issue(vq[i].op, vq[i].va, vq[i].vb);
      count_busy(n);
      chk($sformatf("v%0d_busy_cycles", i), n, vq[i].lat);
      chk($sformatf("v%0d_hi", i), hi, vq[i].ehi);
      chk($sformatf("v%0d_lo", i), lo, vq[i].elo);
    end

    // MTLO issued while busy is dropped; stall_req stays high.
    issue(3'd0, 32'd3, 32'd5);
    start = 1'b1; mdu_op = 3'd5; a = 32'h55; b = 32'd0;
    #1 chk("ign_stall_req", {31'd0, stall_req}, 32'd1);
    @(negedge clk);
    start = 1'b0;
    count_busy(n);
    chk("ign_busy_rest", n, ML - 1);
    chk("ign_lo", lo, 32'd15);
    chk("ign_hi", hi, 32'd0);

    // stall_req is combinational on an idle long-op start.
    start = 1'b1; mdu_op = 3'd2; a = 32'd1; b = 32'd1;
    #1 chk("stall_comb", {31'd0, stall_req}, 32'd1);
    start = 1'b0;
    #1 chk("stall_drop", {31'd0, stall_req}, 32'd0);
    @(negedge clk);

    // Back-to-back MULT on the edge busy falls.
    issue(3'd0, 32'd6, 32'd7);
    nb = 0;
    for (int k = 0; k < ML - 1; k++) begin
      if (busy !== 1'b1) nb++;
      @(negedge clk);
    end
    start = 1'b1; mdu_op = 3'd0; a = 32'd2; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_gaps_first", nb, 0);
    chk("b2b_busy_held", {31'd0, busy}, 32'd1);
    chk("b2b_lo_first", lo, 32'd42);
    count_busy(n);
    chk("b2b_busy_second", n, ML);
    chk("b2b_lo_second", lo, 32'd18);
    chk("b2b_hi_second", hi, 32'd0);

    // Async reset at cycle 3 of a DIV: immediate clear, no later commit.
    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", hi, 32'd0);
    chk("mid_rst_lo", lo, 32'd0);
    #1 reset = 1'b1;
    nb = 0;
    for (int k = 0; k < DL + 2; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) nb++;
    end
    chk("post_rst_busy", nb, 0);
    chk("post_rst_hi", hi, 32'd0);
    chk("post_rst_lo", lo, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
